gold_code_nco_gen: RTL and testbench
====================================

// Module: gold_code_nco_gen
// PURPOSE
//  Parametrised dual-LFSR Gold/PRN code generator for the tracking channels.
//  Generalises the fixed 10-bit C/A generator: configurable register width, tap masks, code length and epoch grouping.
//  Adds early/prompt/late chip taps, a chip index counter, epoch and data-bit-edge strobes, and handshaked code-phase slew.
//  Sits between the channel code NCO (chip_en source) and the E/P/L correlators.
// PARAMETERS
//  LFSR_W     10      width of G1/G2 shift registers; bit 1 = input end, bit LFSR_W = output end
//  G1_TAPS    10'h204 feedback mask for G1; bit k-1 set => stage k in the XOR (default stages 3,10)
//  G2_TAPS    10'h3A6 feedback mask for G2 (default stages 2,3,6,8,9,10)
//  CODE_LEN   1023    chips per code epoch, 2..2^LFSR_W-1
//  CNT_W      10      width of chip index and slew count, >= clog2(CODE_LEN)
//  SEL_W      4       width of G2 phase-select taps t0/t1
//  EPOCH_BIT  20      epochs per data bit, >= 1
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-low
//  chip_en    in   1        advance code one chip this cycle
//  load       in   1        load g1_init/g2_init, clear chip_idx and epoch count
//  g1_init    in   LFSR_W   G1 load/reload value
//  g2_init    in   LFSR_W   G2 load/reload value
//  t0, t1     in   SEL_W    G2 phase-select stages (1..LFSR_W); static between loads
//  slew_valid in   1        slew request
//  slew_chips in   CNT_W    extra chips to advance (0 = no-op)
//  slew_ready out  1        idle, request accepted this cycle if valid
//  chip_e     out  1        early chip = G1[LFSR_W]^G2[t0]^G2[t1] (combinational from state)
//  chip_p     out  1        prompt: chip_e delayed one step
//  chip_l     out  1        late: chip_e delayed two steps
//  chip_idx   out  CNT_W    index of current early chip, 0..CODE_LEN-1
//  epoch      out  1        one-cycle pulse on step that wraps chip_idx to 0
//  bit_edge   out  1        one-cycle pulse on epoch completing EPOCH_BIT epochs
// BEHAVIOUR
//  - Reset: G1=G2=all ones, stored inits=all ones, chip_idx=0, epoch count=0, chip_p=chip_l=0, epoch=bit_edge=0, slew idle (slew_ready=1).
//  - Step: Gx <= {Gx[LFSR_W-1:1], ^(Gx & Gx_TAPS)}; chip_p<=chip_e; chip_l<=chip_p; chip_idx++.
//  - Wrap: step with chip_idx==CODE_LEN-1 sets chip_idx=0, reloads G1/G2 from stored inits (enforces truncated codes), pulses epoch;
//    epoch count wraps EPOCH_BIT-1->0 with bit_edge pulse in same cycle.
//  - Priority per cycle: load > step. load: stores inits, G1/G2<=inits, chip_idx=0, epoch count=0, aborts slew, chip_p/chip_l unchanged, no pulses.
//  - Slew FSM IDLE/SLEW: IDLE & slew_valid & slew_chips!=0 -> SLEW with remaining=slew_chips; slew_chips==0 accepted, stays IDLE.
//    In SLEW a step occurs every cycle; remaining decrements only on cycles with chip_en=0 (chip_en cycles are normal steps).
//    remaining reaching 0 -> IDLE next cycle. slew_ready=0 in SLEW. Exactly one step per cycle max.
//  - Slew steps behave identically to normal steps (E/P/L shift, wrap, epoch, bit_edge).
//  - t0/t1 outside 1..LFSR_W: chip_e undefined; not checked.
//  - Latency: step in cycle n visible on chip_e/chip_p/chip_l/chip_idx after edge n; epoch/bit_edge registered, high cycle n+1 only.
//  - Async reset mid-slew or mid-epoch returns all state to reset values immediately.
// TESTING
//  - Default params, load g1=g2=10'h3FF, t0=2,t1=6 (PRN1), 10 chip_en -> chip_e sequence 1,1,0,0,1,0,0,0,0,0.
//  - Continuous chip_en 2046 steps -> epoch exactly at steps 1023 and 2046, chip_idx 1022->0, sequence repeats identically.
//  - EPOCH_BIT=20, 20460 steps -> 20 epochs, one bit_edge coincident with the 20th epoch.
//  - chip_p/chip_l lag chip_e by 1/2 steps across a wrap; CODE_LEN=7, LFSR_W=3 -> epoch every 7 steps.
//  - Slew 5 chips, chip_en low -> busy 5 cycles, chip_idx +5, slew_ready low then high; with chip_en every 2nd cycle -> chip_idx +5 plus chip_en count.
//  - load asserted during slew at remaining=3 -> slew aborted, chip_idx=0, slew_ready=1 next cycle; rst mid-slew -> all reset values.

Source files
------------

// File: rtl/gold_code_nco_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gold_code_nco_gen_if
//  Purpose  : Control, slew handshake and E/P/L code outputs of the Gold code
//             generator, bundled for the tracking channel.
//  Revision : 1.0  initial release
// ============================================================================
interface gold_code_nco_gen_if #(
   parameter int LFSR_W = 10,
   parameter int CNT_W  = 10,
   parameter int SEL_W  = 4
) ();
   logic              chip_en;
   logic              load;
   logic [LFSR_W-1:0] g1_init;
   logic [LFSR_W-1:0] g2_init;
   logic [SEL_W-1:0]  t0;
   logic [SEL_W-1:0]  t1;
   logic              slew_valid;
   logic [CNT_W-1:0]  slew_chips;
   logic              slew_ready;
   logic              chip_e;
   logic              chip_p;
   logic              chip_l;
   logic [CNT_W-1:0]  chip_idx;
   logic              epoch;
   logic              bit_edge;

   modport slave (
      input  chip_en, load, g1_init, g2_init, t0, t1, slew_valid, slew_chips,
      output slew_ready, chip_e, chip_p, chip_l, chip_idx, epoch, bit_edge
   );

   modport master (
      output chip_en, load, g1_init, g2_init, t0, t1, slew_valid, slew_chips,
      input  slew_ready, chip_e, chip_p, chip_l, chip_idx, epoch, bit_edge
   );
endinterface
`default_nettype wire

// File: rtl/gold_code_nco_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gold_code_nco_gen
//  Purpose  : Dual-LFSR Gold/PRN code generator with E/P/L chips, chip index,
//             epoch / data-bit-edge strobes and handshaked code-phase slew.
//  Revision : 1.0  initial release
// ============================================================================
module gold_code_nco_gen #(
   parameter int                LFSR_W    = 10,
   parameter logic [LFSR_W-1:0] G1_TAPS   = 10'h204,
   parameter logic [LFSR_W-1:0] G2_TAPS   = 10'h3A6,
   parameter int                CODE_LEN  = 1023,
   parameter int                CNT_W     = 10,
   parameter int                SEL_W     = 4,
   parameter int                EPOCH_BIT = 20
) (
   input  wire logic          clk,
   input  wire logic          rst,
   gold_code_nco_gen_if.slave bus
);
   localparam int               c_EPW     = (EPOCH_BIT > 1) ? $clog2(EPOCH_BIT) : 1;
   localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(CODE_LEN - 1);
   localparam logic [c_EPW-1:0] c_EP_LAST = c_EPW'(EPOCH_BIT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SLEW = 1'b1
   } slew_state_t;

   slew_state_t       r_state;
   slew_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_remaining;
   logic [CNT_W-1:0]  w_remaining_nxt;

   logic [LFSR_W:1]   r_g1;
   logic [LFSR_W:1]   r_g2;
   logic [LFSR_W:1]   r_g1_init;
   logic [LFSR_W:1]   r_g2_init;
   logic              r_chip_p;
   logic              r_chip_l;
   logic [CNT_W-1:0]  r_chip_idx;
   logic [c_EPW-1:0]  r_ep_cnt;
   logic              r_epoch;
   logic              r_bit_edge;

   logic              w_step;
   logic              w_wrap;
   logic              w_chip_e;
   logic [LFSR_W:1]   w_g1_shift;
   logic [LFSR_W:1]   w_g2_shift;
   logic [(1 << SEL_W)-1:0] w_g2_ext;

   // Zero-padded copy of G2 so the 1-based phase selects index it directly.
   always_comb begin
      w_g2_ext           = '0;
      w_g2_ext[LFSR_W:1] = r_g2;
   end

   assign w_chip_e   = r_g1[LFSR_W] ^ w_g2_ext[bus.t0] ^ w_g2_ext[bus.t1];
   assign w_g1_shift = {r_g1[LFSR_W-1:1], ^(r_g1 & G1_TAPS)};
   assign w_g2_shift = {r_g2[LFSR_W-1:1], ^(r_g2 & G2_TAPS)};
   assign w_step     = (r_state == S_SLEW) || bus.chip_en;
   assign w_wrap     = (r_chip_idx == c_LAST);

   // Slew: every SLEW cycle steps; only cycles without chip_en consume budget.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      case (r_state)
         S_IDLE: begin
            if (bus.slew_valid && (bus.slew_chips != '0)) begin
               w_state_nxt     = S_SLEW;
               w_remaining_nxt = bus.slew_chips;
            end
         end
         S_SLEW: begin
            if (!bus.chip_en) begin
               w_remaining_nxt = r_remaining - CNT_W'(1);
               if (r_remaining == CNT_W'(1)) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (bus.load) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_g1        <= '1;
         r_g2        <= '1;
         r_g1_init   <= '1;
         r_g2_init   <= '1;
         r_chip_p    <= 1'b0;
         r_chip_l    <= 1'b0;
         r_chip_idx  <= '0;
         r_ep_cnt    <= '0;
         r_epoch     <= 1'b0;
         r_bit_edge  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_epoch     <= 1'b0;
         r_bit_edge  <= 1'b0;
         if (bus.load) begin
            r_g1_init  <= bus.g1_init;
            r_g2_init  <= bus.g2_init;
            r_g1       <= bus.g1_init;
            r_g2       <= bus.g2_init;
            r_chip_idx <= '0;
            r_ep_cnt   <= '0;
         end else if (w_step) begin
            r_chip_p <= w_chip_e;
            r_chip_l <= r_chip_p;
            if (w_wrap) begin
               // Reload rather than shift so codes shorter than the m-sequence repeat.
               r_g1       <= r_g1_init;
               r_g2       <= r_g2_init;
               r_chip_idx <= '0;
               r_epoch    <= 1'b1;
               if (r_ep_cnt == c_EP_LAST) begin
                  r_ep_cnt   <= '0;
                  r_bit_edge <= 1'b1;
               end else begin
                  r_ep_cnt <= r_ep_cnt + c_EPW'(1);
               end
            end else begin
               r_g1       <= w_g1_shift;
               r_g2       <= w_g2_shift;
               r_chip_idx <= r_chip_idx + CNT_W'(1);
            end
         end
      end
   end

   assign bus.slew_ready = (r_state == S_IDLE);
   assign bus.chip_e     = w_chip_e;
   assign bus.chip_p     = r_chip_p;
   assign bus.chip_l     = r_chip_l;
   assign bus.chip_idx   = r_chip_idx;
   assign bus.epoch      = r_epoch;
   assign bus.bit_edge   = r_bit_edge;
endmodule
`default_nettype wire

// File: tb/tb_gold_code_nco_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gold_code_nco_gen
//  Purpose  : Scoreboard bench for gold_code_nco_gen (PRN1 default instance
//             and a 3-bit, 7-chip instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gold_code_nco_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc_cnt  = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done     = 1'b0;
   bit   final_ck = 1'b0;

   int          q_cyc[$];
   int          q_fld[$];
   logic [31:0] q_val[$];

   // Independent PRN1 reference: C/A G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
   bit m_g1[1:10];
   bit m_g2[1:10];

   gold_code_nco_gen_if #(.LFSR_W(10), .CNT_W(10), .SEL_W(4)) ifa ();
   gold_code_nco_gen_if #(.LFSR_W(3),  .CNT_W(3),  .SEL_W(2)) ifb ();

   gold_code_nco_gen dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   gold_code_nco_gen #(
      .LFSR_W(3), .G1_TAPS(3'b110), .G2_TAPS(3'b101), .CODE_LEN(7),
      .CNT_W(3), .SEL_W(2), .EPOCH_BIT(2)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_v(input int f, input logic [31:0] v);
      q_cyc.push_back(cyc_cnt);
      q_fld.push_back(f);
      q_val.push_back(v);
   endtask

   task automatic model_reload();
      for (int s = 1; s <= 10; s++) begin
         m_g1[s] = 1'b1;
         m_g2[s] = 1'b1;
      end
   endtask

   task automatic model_step();
      bit f1, f2;
      f1 = m_g1[3] ^ m_g1[10];
      f2 = m_g2[2] ^ m_g2[3] ^ m_g2[6] ^ m_g2[8] ^ m_g2[9] ^ m_g2[10];
      for (int s = 10; s >= 2; s--) begin
         m_g1[s] = m_g1[s-1];
         m_g2[s] = m_g2[s-1];
      end
      m_g1[1] = f1;
      m_g2[1] = f2;
   endtask

   function automatic bit model_chip();
      return m_g1[10] ^ m_g2[2] ^ m_g2[6];
   endfunction

   function automatic logic [31:0] actual(input int f);
      logic [31:0] r;
      r = '0;
      case (f)
         0:  r = 32'(ifa.chip_e);
         1:  r = 32'(ifa.chip_p);
         2:  r = 32'(ifa.chip_l);
         3:  r = 32'(ifa.chip_idx);
         4:  r = 32'(ifa.epoch);
         5:  r = 32'(ifa.bit_edge);
         6:  r = 32'(ifa.slew_ready);
         10: r = 32'(ifb.chip_e);
         11: r = 32'(ifb.chip_p);
         12: r = 32'(ifb.chip_l);
         13: r = 32'(ifb.chip_idx);
         14: r = 32'(ifb.epoch);
         15: r = 32'(ifb.bit_edge);
         default: r = 'x;
      endcase
      return r;
   endfunction

   function automatic string fname(input int f);
      string s;
      case (f)
         0: s = "a.chip_e";   1: s = "a.chip_p";  2: s = "a.chip_l";
         3: s = "a.chip_idx"; 4: s = "a.epoch";   5: s = "a.bit_edge";
         6: s = "a.slew_ready";
         10: s = "b.chip_e";  11: s = "b.chip_p"; 12: s = "b.chip_l";
         13: s = "b.chip_idx"; 14: s = "b.epoch"; 15: s = "b.bit_edge";
         default: s = "unknown";
      endcase
      return s;
   endfunction

   // Monitor: every entry queued for the current cycle is checked mid-cycle.
   always @(negedge clk) begin : mon
      int          c, f;
      logic [31:0] v, a;
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc_cnt) begin
         c = q_cyc.pop_front();
         f = q_fld.pop_front();
         v = q_val.pop_front();
         n_checks++;
         if (c != cyc_cnt) begin
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", fname(f), c, cyc_cnt);
         end else begin
            a = actual(f);
            if (a !== v) begin
               n_fail++;
               $display("FAIL %s @cycle %0d: got %0h, expected %0h", fname(f), cyc_cnt, a, v);
            end
         end
      end
      if (done && !final_ck) begin
         final_ck = 1'b1;
         n_checks++;
         if (q_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q_cyc.size());
         end
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [9:0] prn1_first;
      logic [6:0] e_seq;
      bit         cur, p_m, l_m;
      prn1_first = 10'b00_0001_0011;   // PRN1 chips 0..9: 1,1,0,0,1,0,0,0,0,0
      e_seq      = 7'b000_1001;        // 3-bit instance chips 0..6: 1,0,0,1,0,0,0

      ifa.chip_en = 1'b0; ifa.load = 1'b0; ifa.slew_valid = 1'b0; ifa.slew_chips = '0;
      ifa.g1_init = 10'h3FF; ifa.g2_init = 10'h3FF; ifa.t0 = 4'd2; ifa.t1 = 4'd6;
      ifb.chip_en = 1'b0; ifb.load = 1'b0; ifb.slew_valid = 1'b0; ifb.slew_chips = '0;
      ifb.g1_init = 3'b111; ifb.g2_init = 3'b111; ifb.t0 = 2'd1; ifb.t1 = 2'd2;
      rst = 1'b0;
      repeat (3) tick();

      // Reset state
      exp_v(0, 1); exp_v(1, 0); exp_v(2, 0); exp_v(3, 0); exp_v(4, 0); exp_v(5, 0); exp_v(6, 1);
      exp_v(10, 1); exp_v(11, 0); exp_v(12, 0); exp_v(13, 0); exp_v(14, 0); exp_v(15, 0);
      rst = 1'b1;
      tick();

      // Short code: epoch every 7 steps, bit_edge every 2 epochs, P/L lag across wraps
      ifb.load = 1'b1; tick(); ifb.load = 1'b0;
      exp_v(13, 0); exp_v(10, 1); exp_v(11, 0); exp_v(12, 0); exp_v(14, 0);
      ifb.chip_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_v(13, 32'(k % 7));
         exp_v(10, 32'(e_seq[k % 7]));
         exp_v(11, 32'(e_seq[(k - 1) % 7]));
         exp_v(12, (k >= 2) ? 32'(e_seq[(k - 2) % 7]) : 32'd0);
         exp_v(14, 32'(k % 7 == 0));
         exp_v(15, 32'(k == 14));
      end
      ifb.chip_en = 1'b0;

      // PRN1 continuous run: 20 epochs, one bit_edge
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      exp_v(3, 0); exp_v(0, 32'(prn1_first[0])); exp_v(4, 0);
      model_reload();
      cur = model_chip(); p_m = 1'b0; l_m = 1'b0;
      ifa.chip_en = 1'b1;
      for (int n = 1; n <= 20460; n++) begin
         tick();
         l_m = p_m;
         p_m = cur;
         if (n % 1023 == 0) model_reload();
         else model_step();
         cur = model_chip();
         exp_v(3, 32'(n % 1023));
         exp_v(4, 32'(n % 1023 == 0));
         exp_v(5, 32'(n == 20460));
         if (n <= 2046) begin
            exp_v(0, 32'(cur)); exp_v(1, 32'(p_m)); exp_v(2, 32'(l_m));
            if (n % 1023 < 10) exp_v(0, 32'(prn1_first[n % 1023]));
         end
      end
      ifa.chip_en = 1'b0;

      // Zero-chip slew: accepted, no busy cycles, no movement
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      ifa.slew_valid = 1'b1; ifa.slew_chips = 10'd0;
      exp_v(6, 1);
      tick(); ifa.slew_valid = 1'b0;
      exp_v(6, 1); exp_v(3, 0);
      tick();
      exp_v(6, 1); exp_v(3, 0);

      // Slew 5 chips with chip_en low
      ifa.slew_valid = 1'b1; ifa.slew_chips = 10'd5;
      exp_v(6, 1);
      tick(); ifa.slew_valid = 1'b0;
      exp_v(6, 0); exp_v(3, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         exp_v(3, 32'(k)); exp_v(6, 32'(k == 5));
      end

      // Slew 5 chips with chip_en every second cycle: 10 steps, 10 busy cycles
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      ifa.slew_valid = 1'b1; ifa.slew_chips = 10'd5;
      tick(); ifa.slew_valid = 1'b0;
      exp_v(6, 0); exp_v(3, 0);
      for (int i = 0; i < 10; i++) begin
         ifa.chip_en = (i % 2 == 0);
         tick();
         exp_v(3, 32'(i + 1)); exp_v(6, 32'(i == 9));
      end
      ifa.chip_en = 1'b0;
      tick();
      exp_v(3, 10); exp_v(6, 1);

      // load with remaining=3 aborts the slew
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      ifa.slew_valid = 1'b1; ifa.slew_chips = 10'd5;
      tick(); ifa.slew_valid = 1'b0;
      tick(); tick();
      exp_v(3, 2); exp_v(6, 0);
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      exp_v(3, 0); exp_v(6, 1); exp_v(0, 1); exp_v(4, 0);
      tick();
      exp_v(3, 0); exp_v(6, 1);

      // Asynchronous reset mid-slew
      ifa.slew_valid = 1'b1; ifa.slew_chips = 10'd5;
      tick(); ifa.slew_valid = 1'b0;
      tick();
      exp_v(3, 1); exp_v(6, 0);
      tick();
      rst = 1'b0;
      #1;
      exp_v(3, 0); exp_v(6, 1); exp_v(1, 0); exp_v(2, 0); exp_v(4, 0); exp_v(0, 1);
      tick();
      rst = 1'b1;
      exp_v(3, 0); exp_v(6, 1);
      tick();
      exp_v(3, 0); exp_v(6, 1);

      tick();
      done = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
